// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one step per clock.
// Optional invalid-digit detection is enabled by defining INVALID_CHECK_EN.
module bcd_to_bin #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e            state_q, state_d;
  logic [BcdW-1:0]   sh_bcd_q, sh_bcd_d;
  logic [BIN_W-1:0]  sh_bin_q, sh_bin_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              err_q, err_d;

  logic [BcdW-1:0]   bcd_shifted, bcd_fixed;
  logic [BIN_W-1:0]  bin_shifted;
  logic              invalid;

`ifdef INVALID_CHECK_EN
  always_comb begin
    invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) invalid = 1'b1;
    end
  end
`else
  assign invalid = 1'b0;
`endif

  // One reverse double-dabble step: shift the pair right, then pull every digit >= 8 down by 3.
  always_comb begin
    bcd_shifted = sh_bcd_q >> 1;
    bin_shifted = {sh_bcd_q[0], sh_bin_q[BIN_W-1:1]};
    bcd_fixed   = bcd_shifted;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_shifted[4*i +: 4] >= 4'd8) bcd_fixed[4*i +: 4] = bcd_shifted[4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    state_d  = state_q;
    sh_bcd_d = sh_bcd_q;
    sh_bin_d = sh_bin_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    bin_d    = bin_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (invalid) begin
            state_d = StDone;
            done_d  = 1'b1;
            err_d   = 1'b1;
            bin_d   = '0;
          end else begin
            state_d  = StConv;
            sh_bcd_d = bcd_in;
            sh_bin_d = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
            err_d    = 1'b0;
          end
        end
      end
      StConv: begin
        sh_bcd_d = bcd_fixed;
        sh_bin_d = bin_shifted;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntW'(BIN_W - 1)) begin
          state_d = StDone;
          bin_d   = bin_shifted;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      sh_bcd_q <= '0;
      sh_bin_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bin_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_bcd_q <= sh_bcd_d;
      sh_bin_q <= sh_bin_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bin_q    <= bin_d;
      err_q    <= err_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bin_out = bin_q;
  assign err     = err_q;

endmodule
